// File: rtl/fifo_sync_module.sv
// fifo_sync_module: single-clock FIFO with a registered fill level, programmable
// almost-full/almost-empty thresholds, registered or first-word-fall-through read,
// synchronous flush and sticky overflow/underflow flags.
// Optional feature: define FIFO_SYNC_PEAK_TRACK_EN to add the peak_level
// high-water-mark output.
module fifo_sync_module #(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0,
   // Derived width of the level port; leave at its default.
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_bus_in,
   input  logic             write_ins,
   output logic [WIDTH-1:0] data_bus_out,
   input  logic             read_ins,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CNT_W-1:0] level,
   output logic             overflow,
   output logic             underflow
`ifdef FIFO_SYNC_PEAK_TRACK_EN
   ,
   output logic [CNT_W-1:0] peak_level
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LVL_AF   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] LVL_AE   = CNT_W'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] level_q, level_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             wr_acc, rd_acc;
   logic             clear;

   // Status flags come only from the level register, never from the request inputs.
   always_comb begin
      level        = level_q;
      full         = (level_q == LVL_FULL);
      empty        = (level_q == '0);
      almost_full  = (level_q >= LVL_AF);
      almost_empty = (level_q <= LVL_AE);
      overflow     = ovf_q;
      underflow    = unf_q;
   end

   // Request acceptance and next-state for pointers, level and error flags.
   always_comb begin
      clear    = enable && flush;
      // Flush wins over both requests; full/empty are the pre-edge values.
      wr_acc   = enable && !flush && write_ins && !full;
      rd_acc   = enable && !flush && read_ins && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else if (enable) begin
         // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
         if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         unique case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
         endcase
         if (write_ins && full) begin
            ovf_d = 1'b1;
         end
         if (read_ins && empty) begin
            unf_d = 1'b1;
         end
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array; not reset, contents are only observable once written.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= data_bus_in;
      end
   end

   if (FWFT != 0) begin : gen_fwft
      // Head word is shown directly; driven to zero while empty so the port has a
      // defined value after reset and flush.
      always_comb begin
         data_bus_out = empty ? '0 : mem[rd_ptr_q];
      end
   end else begin : gen_reg_read
      logic [WIDTH-1:0] dout_q;

      // Registered read: output updates only on an accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q <= '0;
         end else if (rd_acc) begin
            dout_q <= mem[rd_ptr_q];
         end
      end

      always_comb begin
         data_bus_out = dout_q;
      end
   end

`ifdef FIFO_SYNC_PEAK_TRACK_EN
   logic [CNT_W-1:0] peak_q;

   // High-water mark of level, tracked against the next level value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= '0;
      end else if (clear) begin
         peak_q <= '0;
      end else if (level_d > peak_q) begin
         peak_q <= level_d;
      end
   end

   always_comb begin
      peak_level = peak_q;
   end
`endif

endmodule
